// File: rtl/pwm_fade_seq.sv
// PWM duty fade sequencer: steps one channel's duty register toward a target through a shared register write port.
// Optional macro PWM_FADE_SEQ_ABORT_EN: a host write to the fading channel's duty register aborts the fade.
module pwm_fade_seq #(
  parameter int REG_WIDTH      = 16,
  parameter int NUM_CHANNELS   = 4,
  parameter int INTERVAL_WIDTH = 16,
  localparam int CH_W          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              host_wr_en,
  input  logic [4:0]                        host_wr_addr,
  input  logic [31:0]                       host_wr_data,
  input  logic                              fade_start,
  input  logic [CH_W-1:0]                   fade_ch,
  input  logic [REG_WIDTH-1:0]              fade_target,
  input  logic [REG_WIDTH-1:0]              fade_step,
  input  logic [INTERVAL_WIDTH-1:0]         fade_interval,
  input  logic [NUM_CHANNELS*REG_WIDTH-1:0] duty_in,
  output logic                              reg_write_en,
  output logic [4:0]                        reg_write_addr,
  output logic [31:0]                       reg_write_data,
  output logic                              fade_busy,
  output logic                              fade_done,
  output logic                              fade_abort
);

  typedef enum logic [1:0] {IDLE, WAIT, STEP, DONE} state_e;

  state_e                    state_q, state_d;
  logic [CH_W-1:0]           ch_q;
  logic [REG_WIDTH-1:0]      target_q, step_q, cur_q;
  logic [INTERVAL_WIDTH-1:0] interval_q, cnt_q;

  logic [REG_WIDTH-1:0]      duty_arr [NUM_CHANNELS];
  logic [REG_WIDTH-1:0]      start_duty, next_duty, diff;
  logic [4:0]                duty_addr;
  logic                      fade_wr, abort_hit, wait_over;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_duty
    assign duty_arr[c] = duty_in[c*REG_WIDTH +: REG_WIDTH];
  end

  assign start_duty = duty_arr[fade_ch];
  assign duty_addr  = 5'(2 + 2 * int'(ch_q));
  assign wait_over  = (cnt_q == interval_q - INTERVAL_WIDTH'(1));
  // The host always wins the port; a colliding step write simply waits in STEP.
  assign fade_wr    = (state_q == STEP) && !host_wr_en;

`ifdef PWM_FADE_SEQ_ABORT_EN
  assign abort_hit = host_wr_en && (host_wr_addr == duty_addr) &&
                     ((state_q == WAIT) || (state_q == STEP));
`else
  assign abort_hit = 1'b0;
`endif

  // Saturating step toward the target: the distance is compared first so cur +/- step never wraps.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    diff      = '0;
    next_duty = cur_q;
    if (target_q >= cur_q) begin
      diff      = target_q - cur_q;
      next_duty = (diff <= step_q) ? target_q : cur_q + step_q;
    end else begin
      diff      = cur_q - target_q;
      next_duty = (diff <= step_q) ? target_q : cur_q - step_q;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fade_start) state_d = (start_duty == fade_target) ? DONE : WAIT;
      WAIT: begin
        if (abort_hit)      state_d = IDLE;
        else if (wait_over) state_d = STEP;
      end
      STEP: begin
        if (abort_hit)    state_d = IDLE;
        else if (fade_wr) state_d = (next_duty == target_q) ? DONE : WAIT;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q       <= '0;
      target_q   <= '0;
      step_q     <= '0;
      interval_q <= '0;
      cur_q      <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (fade_start) begin
          ch_q       <= fade_ch;
          target_q   <= fade_target;
          step_q     <= (fade_step == '0) ? REG_WIDTH'(1) : fade_step;
          interval_q <= (fade_interval == '0) ? INTERVAL_WIDTH'(1) : fade_interval;
          cur_q      <= start_duty;
          cnt_q      <= '0;
        end
        // Counter wraps to zero on leaving WAIT so the next interval starts clean.
        WAIT: cnt_q <= wait_over ? '0 : cnt_q + INTERVAL_WIDTH'(1);
        STEP: if (fade_wr) cur_q <= next_duty;
        default: ;
      endcase
    end
  end

  always_comb begin
    reg_write_en   = 1'b0;
    reg_write_addr = '0;
    reg_write_data = '0;
    fade_busy      = 1'b0;
    fade_done      = 1'b0;
    fade_abort     = 1'b0;
    if (!rst) begin
      if (host_wr_en) begin
        reg_write_en   = 1'b1;
        reg_write_addr = host_wr_addr;
        reg_write_data = host_wr_data;
      end else if (fade_wr) begin
        reg_write_en   = 1'b1;
        reg_write_addr = duty_addr;
        reg_write_data = 32'(next_duty);
      end
      fade_busy  = (state_q == WAIT) || (state_q == STEP);
      fade_done  = (state_q == DONE);
      fade_abort = abort_hit;
    end
  end

endmodule

// File: tb/tb_pwm_fade_seq.sv
// Scoreboard bench for pwm_fade_seq: directed fades push expected write/done/abort events with
// their cycle stamps; a negedge monitor pops and compares every event the DUT presents.
module tb_pwm_fade_seq;

  typedef enum {EV_WR, EV_DONE, EV_ABORT} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_wr_en;
  logic [4:0]  host_wr_addr;
  logic [31:0] host_wr_data;
  logic        fade_start;
  logic [1:0]  fade_ch;
  logic [15:0] fade_target, fade_step, fade_interval;
  logic [63:0] duty_in;
  logic        reg_write_en;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data;
  logic        fade_busy, fade_done, fade_abort;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;

  pwm_fade_seq dut (
    .clk(clk), .rst(rst),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .fade_start(fade_start), .fade_ch(fade_ch), .fade_target(fade_target),
    .fade_step(fade_step), .fade_interval(fade_interval), .duty_in(duty_in),
    .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr), .reg_write_data(reg_write_data),
    .fade_busy(fade_busy), .fade_done(fade_done), .fade_abort(fade_abort)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input string detail);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  task automatic expect_ev(input ev_kind_e k, input int a, input int d, input int c);
    ev_t e;
    e.kind = k; e.addr = 5'(a); e.data = 32'(d); e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic check_event(input ev_kind_e k, input logic [4:0] a, input logic [31:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      check(1'b0, "unexpected_event",
            $sformatf("got %s (%0h,%0d) at cyc %0d, required no event", k.name(), a, d, cyc));
    end else begin
      e = exp_q.pop_front();
      check(e.kind == k && e.cyc == cyc && (k != EV_WR || (e.addr == a && e.data == d)), "event",
            $sformatf("got %s (%0h,%0d)@%0d, required %s (%0h,%0d)@%0d",
                      k.name(), a, d, cyc, e.kind.name(), e.addr, e.data, e.cyc));
    end
  endtask

  // Monitor: write, then done, then abort within one cycle, matching push order.
  always @(negedge clk) begin
    if (reg_write_en) check_event(EV_WR, reg_write_addr, reg_write_data);
    if (fade_done)    check_event(EV_DONE, 5'd0, 32'd0);
    if (fade_abort)   check_event(EV_ABORT, 5'd0, 32'd0);
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic set_duty(input int ch, input int v);
    duty_in[ch*16 +: 16] = 16'(v);
  endtask

  task automatic start(input int ch, input int tgt, input int stp, input int iv);
    fade_start    = 1'b1;
    fade_ch       = 2'(ch);
    fade_target   = 16'(tgt);
    fade_step     = 16'(stp);
    fade_interval = 16'(iv);
    @(posedge clk); #1;
    fade_start = 1'b0;
  endtask

  task automatic drain(input string name, input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || fade_busy || fade_done) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check(exp_q.size() == 0 && !fade_busy, name,
          $sformatf("pending=%0d busy=%0b, required pending=0 busy=0", exp_q.size(), fade_busy));
  endtask

  initial begin
    int s;
    rst = 1'b1; host_wr_en = 1'b1; host_wr_addr = 5'h02; host_wr_data = 32'hdead;
    fade_start = 1'b0; fade_ch = '0; fade_target = '0; fade_step = '0; fade_interval = '0;
    duty_in = '0;
    @(posedge clk); #1; @(posedge clk); #1;
    check(reg_write_en == 1'b0, "rst_wr_en", $sformatf("got %0b, required 0", reg_write_en));
    check(reg_write_addr == 5'd0 && reg_write_data == 32'd0, "rst_addr_data",
          $sformatf("got (%0h,%0h), required (0,0)", reg_write_addr, reg_write_data));
    check(!fade_busy && !fade_done && !fade_abort, "rst_status",
          $sformatf("got busy=%0b done=%0b abort=%0b, required 0/0/0", fade_busy, fade_done, fade_abort));
    host_wr_en = 1'b0; rst = 1'b0;
    @(posedge clk); #1;

    // Host passthrough while idle.
    expect_ev(EV_WR, 5'h01, 32'h55, cyc);
    host_wr_en = 1'b1; host_wr_addr = 5'h01; host_wr_data = 32'h55;
    @(posedge clk); #1;
    host_wr_en = 1'b0;
    drain("idle_host", 10);

    // Up-fade on ch0, interval 4: writes five cycles apart.
    set_duty(0, 100); s = cyc;
    expect_ev(EV_WR, 2, 110, s + 5);
    expect_ev(EV_WR, 2, 120, s + 10);
    expect_ev(EV_WR, 2, 130, s + 15);
    expect_ev(EV_DONE, 0, 0, s + 16);
    start(0, 130, 10, 4);
    check(fade_busy == 1'b1, "up_busy", $sformatf("got %0b, required 1", fade_busy));
    drain("up_fade", 40);

    // Saturating down-fade on ch1: single clamped write.
    set_duty(1, 50); s = cyc;
    expect_ev(EV_WR, 4, 45, s + 2);
    expect_ev(EV_DONE, 0, 0, s + 3);
    start(1, 45, 10, 1);
    drain("down_sat", 20);

    // Host collision with the STEP cycle on ch2.
    set_duty(2, 10); s = cyc;
    expect_ev(EV_WR, 0, 123, s + 3);
    expect_ev(EV_WR, 6, 11, s + 4);
    expect_ev(EV_WR, 6, 12, s + 7);
    expect_ev(EV_DONE, 0, 0, s + 8);
    start(2, 12, 1, 2);
    goto(s + 3);
    host_wr_en = 1'b1; host_wr_addr = 5'h00; host_wr_data = 32'd123;
    goto(s + 4);
    host_wr_en = 1'b0;
    drain("collision", 30);

    // Host write to the fading duty register during WAIT.
    set_duty(0, 0); s = cyc;
    expect_ev(EV_WR, 2, 5, s + 4);
    expect_ev(EV_WR, 2, 7, s + 6);
`ifdef PWM_FADE_SEQ_ABORT_EN
    expect_ev(EV_ABORT, 0, 0, s + 6);
`else
    expect_ev(EV_WR, 2, 10, s + 8);
    expect_ev(EV_WR, 2, 15, s + 12);
    expect_ev(EV_WR, 2, 20, s + 16);
    expect_ev(EV_DONE, 0, 0, s + 17);
`endif
    start(0, 20, 5, 3);
    goto(s + 6);
    host_wr_en = 1'b1; host_wr_addr = 5'h02; host_wr_data = 32'd7;
    goto(s + 7);
    host_wr_en = 1'b0;
    drain("host_dup_addr", 40);
    goto(s + 24);
    check(exp_q.size() == 0 && !fade_busy, "after_dup_addr",
          $sformatf("pending=%0d busy=%0b, required 0/0", exp_q.size(), fade_busy));

    // Target already reached: done with no write.
    set_duty(3, 77); s = cyc;
    expect_ev(EV_DONE, 0, 0, s + 1);
    start(3, 77, 4, 4);
    drain("trivial", 10);

    // step=0 and interval=0 act as 1; a second start while busy is ignored.
    s = cyc;
    expect_ev(EV_WR, 8, 78, s + 2);
    expect_ev(EV_WR, 8, 79, s + 4);
    expect_ev(EV_WR, 8, 80, s + 6);
    expect_ev(EV_DONE, 0, 0, s + 7);
    start(3, 80, 0, 0);
    start(0, 500, 1, 1);
    drain("unit_steps", 20);

    // Reset mid-fade while in WAIT.
    set_duty(1, 50); s = cyc;
    start(1, 100, 10, 5);
    goto(s + 2);
    rst = 1'b1;
    goto(s + 3);
    rst = 1'b0;
    check(!reg_write_en && reg_write_addr == 5'd0 && reg_write_data == 32'd0, "midrst_port",
          $sformatf("got en=%0b (%0h,%0h), required 0 (0,0)", reg_write_en, reg_write_addr, reg_write_data));
    check(!fade_busy && !fade_done && !fade_abort, "midrst_status",
          $sformatf("got busy=%0b done=%0b abort=%0b, required 0/0/0", fade_busy, fade_done, fade_abort));
    goto(s + 25);
    check(!fade_busy && exp_q.size() == 0, "midrst_quiet",
          $sformatf("busy=%0b pending=%0d, required 0/0", fade_busy, exp_q.size()));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/pwm_fade_seq.md
PWM_FADE_SEQ -- requirements
Module: pwm_fade_seq

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 16, width of duty, target and step values.
REQ-002 SHALL have parameter NUM_CHANNELS, default 4, number of PWM channels; CH_W = max(1, clog2(NUM_CHANNELS)).
REQ-003 SHALL have parameter INTERVAL_WIDTH, default 16, width of the step-interval counter.
REQ-004 SHALL use one clock with synchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  synchronous active-high reset.
REQ-005 SHALL have ports host_wr_en  input  1  host register write strobe; host_wr_addr  input  5  host register address; host_wr_data  input  32  host write data.
REQ-006 SHALL have ports fade_start  input  1  one-cycle fade request; fade_ch  input  CH_W  channel to fade; fade_target  input  REG_WIDTH  final duty; fade_step  input  REG_WIDTH  duty increment per step; fade_interval  input  INTERVAL_WIDTH  clocks between steps.
REQ-007 SHALL have port duty_in  input  NUM_CHANNELS x REG_WIDTH  current duty values from the register block.
REQ-008 SHALL have ports reg_write_en  output  1; reg_write_addr  output  5; reg_write_data  output  32: the single write port into the register block.
REQ-009 SHALL have ports fade_busy  output  1  fade active; fade_done  output  1  one-cycle completion pulse; fade_abort  output  1  one-cycle abort pulse.

Function
REQ-010 SHALL use the register map prescale 0x00, period[c] at 1+2c, duty[c] at 2+2c.
REQ-011 SHALL implement the FSM states IDLE, WAIT, STEP and DONE.
REQ-012 SHALL, in IDLE, on fade_start, latch ch, target, step (0 treated as 1), interval (0 treated as 1) and cur = duty_in[ch].
REQ-013 SHALL, on that start, go to DONE with no write if cur == target, else to WAIT with the counter cleared.
REQ-014 SHALL leave WAIT for STEP after exactly max(interval,1) clk edges in WAIT.
REQ-015 SHALL compute next in STEP as cur±step toward target; if |target-cur| <= step, next = target, with no wrap or overshoot.
REQ-016 SHALL, in STEP, drive reg_write_en=1, addr = 2+2ch and data = next zero-extended to 32 bits for one cycle, then set cur = next.
REQ-017 SHALL, after a STEP write, go to DONE if next == target, else to WAIT.
REQ-018 SHALL pulse fade_done for exactly one cycle in DONE, then return to IDLE.
REQ-019 SHALL hold fade_busy high in WAIT and STEP, and low in IDLE and DONE.
REQ-020 SHALL give the host fixed priority: host_wr_en drives the write port combinationally in the same cycle, passing addr/data through.
REQ-021 SHALL, when host_wr_en and STEP coincide, keep the fade in STEP and issue its write in the next free cycle, with no write lost or duplicated.
REQ-022 SHALL ignore fade_start while not in IDLE.
REQ-023 SHALL keep the fade writes separated by max(interval,1)+1 cycles when there are no host collisions.

Reset
REQ-024 SHALL, while rst is sampled high, go to IDLE and drive reg_write_en, reg_write_addr, reg_write_data, fade_busy, fade_done and fade_abort to 0.
REQ-025 SHALL clear the latched ch/target/step/interval/cur and the counter on reset.
REQ-026 SHALL, on rst asserted mid-fade, stop the fade with no fade_done and no fade_abort pulse and no further fade writes.

Configuration
REQ-027 SHALL, with macro PWM_FADE_SEQ_ABORT_EN defined, abort the fade on a host write to duty address 2+2ch of the fading channel in WAIT or STEP.
REQ-028 SHALL, on such an abort, pass the host write through, pulse fade_abort for one cycle, go to IDLE and drop any pending step write.
REQ-029 SHALL, with PWM_FADE_SEQ_ABORT_EN undefined, tie fade_abort to 0, pass host writes through and continue the fade from its internal cur.

Verification
REQ-030 SHALL cover an up-fade: duty_in[0]=100, start ch0 target=130 step=10 interval=4 -> writes (0x02,110),(0x02,120),(0x02,130) 5 cycles apart, one fade_done pulse, busy low after.
REQ-031 SHALL cover a saturating down-fade: duty_in[1]=50, target=45 step=10 interval=1 -> single write (0x04,45), then fade_done.
REQ-032 SHALL cover a collision: host write (0x00,123) in the STEP cycle -> port shows (0x00,123), then the fade write one cycle later, with the total write count correct.
REQ-033 SHALL cover an abort: macro defined, host write (0x02,7) during a ch0 fade -> fade_abort pulse and no further writes to 0x02; macro undefined -> the fade continues to target.
REQ-034 SHALL cover the trivial cases: target == duty_in -> fade_done with no write; step=0 -> unit steps; fade_start while busy -> ignored.
REQ-035 SHALL cover reset mid-fade: rst high in WAIT -> all outputs 0 next cycle and no fade_done.
